aes_block_assembler: RTL and testbench

- Upstream stage of the 128-bit byte-splitter. Collects a serial byte stream (UART/host side) into one 128-bit AES state word and presents it on a valid/ready interface.
- Byte ordering matches the splitter. The first byte received lands in bits [7:0] (part0). Byte k lands in bits [8k+7:8k]. The 16th byte lands in [127:120] (part15).
- Sits between the byte-wide host interface and the 128-bit datapath feeding the splitter and round logic.

---
 rtl/aes_pkg.sv | 15 +
 rtl/aes_idle_timer.sv | 30 +++
 rtl/aes_block_assembler.sv | 118 +++++++++++
 tb/tb_aes_block_assembler.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES datapath constants and types for the byte assembler and splitter.
package aes_pkg;

    localparam int unsigned AES_BYTE_W    = 8;
    localparam int unsigned AES_NUM_BYTES = 16;
    localparam int unsigned AES_BLOCK_W   = AES_BYTE_W * AES_NUM_BYTES;

    typedef logic [AES_BLOCK_W-1:0] aes_block_t;

    typedef enum logic [0:0] {
        FILL = 1'b0,
        HOLD = 1'b1
    } asm_state_e;

endpackage : aes_pkg

// File: rtl/aes_idle_timer.sv
// Loadable idle down-counter: reloads on clr or while disabled, flags expiry
// combinationally on the last idle cycle.
module aes_idle_timer #(
    parameter int unsigned CYCLES = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic expire_c
);

    localparam int unsigned TW = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam logic [TW-1:0] LOAD = TW'(CYCLES - 1);

    logic [TW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= LOAD;
        end else if (clr || !en) begin
            cnt <= LOAD;
        end else if (cnt != '0) begin
            cnt <= cnt - TW'(1);
        end
    end

    assign expire_c = en && !clr && (cnt == '0);

endmodule : aes_idle_timer

// File: rtl/aes_block_assembler.sv
// Collects a byte stream into one AES block (first byte in bits [7:0]) behind valid/ready.
// Optional partial-block idle timeout enabled by defining AES_ASM_TIMEOUT_EN.
module aes_block_assembler
    import aes_pkg::*;
#(
    parameter int unsigned BYTE_W         = AES_BYTE_W,
    parameter int unsigned NUM_BYTES      = AES_NUM_BYTES,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [BYTE_W-1:0]           byte_in,
    input  logic                        byte_valid,
    output logic                        byte_ready,
    output logic [BYTE_W*NUM_BYTES-1:0] block_out,
    output logic                        block_valid,
    input  logic                        block_ready,
    input  logic                        flush,
    output logic [$clog2(NUM_BYTES):0]  byte_count,
    output logic                        err_timeout
);

    localparam int unsigned BLOCK_W = BYTE_W * NUM_BYTES;
    localparam int unsigned CNT_W   = $clog2(NUM_BYTES) + 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_BYTES - 1);

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("aes_block_assembler: TIMEOUT_CYCLES must be at least 2");
    end

    asm_state_e         state_q, state_d;
    logic               accept_c;
    logic               timeout_c;
    logic [CNT_W-1:0]   count_d;
    logic [BLOCK_W-1:0] block_d;
    logic               ready_d, valid_d, err_d;

    // byte_ready is registered so it stays low through reset
    assign accept_c = (state_q == FILL) && byte_valid && byte_ready && !flush;

`ifdef AES_ASM_TIMEOUT_EN
    aes_idle_timer #(
        .CYCLES (TIMEOUT_CYCLES)
    ) u_idle_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       ((state_q == FILL) && (byte_count != '0)),
        .clr      (accept_c || flush),
        .expire_c (timeout_c)
    );
`else
    assign timeout_c = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FILL;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FILL: if (accept_c && (byte_count == LAST_IDX)) state_d = HOLD;
            HOLD: if (block_ready) state_d = FILL;
            default: state_d = FILL;
        endcase
    end

    // Next values for the registered outputs; flush beats a same-cycle byte
    always_comb begin
        count_d = byte_count;
        block_d = block_out;
        err_d   = 1'b0;
        ready_d = (state_d == FILL);
        valid_d = (state_d == HOLD);
        case (state_q)
            FILL: begin
                if (flush) begin
                    count_d = '0;
                end else if (accept_c) begin
                    for (int unsigned i = 0; i < NUM_BYTES; i++) begin
                        if (byte_count == CNT_W'(i)) begin
                            block_d[i*BYTE_W +: BYTE_W] = byte_in;
                        end
                    end
                    count_d = byte_count + CNT_W'(1);
                end else if (timeout_c) begin
                    count_d = '0;
                    err_d   = 1'b1;
                end
            end
            HOLD: begin
                if (block_ready) count_d = '0;
            end
            default: count_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_count  <= '0;
            block_out   <= '0;
            byte_ready  <= 1'b0;
            block_valid <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            byte_count  <= count_d;
            block_out   <= block_d;
            byte_ready  <= ready_d;
            block_valid <= valid_d;
            err_timeout <= err_d;
        end
    end

endmodule : aes_block_assembler

// File: tb/tb_aes_block_assembler.sv
// Directed bench for aes_block_assembler; the timeout scenario follows AES_ASM_TIMEOUT_EN.
module tb_aes_block_assembler;

    logic         clk;
    logic         rst_n;
    logic [7:0]   byte_in;
    logic         byte_valid;
    logic         byte_ready;
    logic [127:0] block_out;
    logic         block_valid;
    logic         block_ready;
    logic         flush;
    logic [4:0]   byte_count;
    logic         err_timeout;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [127:0] BLK_00 = 128'h0F0E0D0C0B0A09080706050403020100;
    localparam logic [127:0] BLK_10 = 128'h1F1E1D1C1B1A19181716151413121110;
    localparam logic [127:0] BLK_A0 = 128'hAFAEADACABAAA9A8A7A6A5A4A3A2A1A0;
    localparam logic [127:0] BLK_C0 = 128'hCFCECDCCCBCAC9C8C7C6C5C4C3C2C1C0;
    localparam logic [127:0] BLK_D0 = 128'hDFDEDDDCDBDAD9D8D7D6D5D4D3D2D1D0;

    aes_block_assembler #(
        .BYTE_W         (8),
        .NUM_BYTES      (16),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .byte_in     (byte_in),
        .byte_valid  (byte_valid),
        .byte_ready  (byte_ready),
        .block_out   (block_out),
        .block_valid (block_valid),
        .block_ready (block_ready),
        .flush       (flush),
        .byte_count  (byte_count),
        .err_timeout (err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: inputs change and outputs are sampled on the falling edge
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send_bytes(input logic [7:0] first, input int n);
        for (int i = 0; i < n; i++) begin
            byte_valid = 1'b1;
            byte_in    = first + 8'(i);
            tick();
        end
        byte_valid = 1'b0;
    endtask

    initial begin
        rst_n       = 1'b1;
        byte_in     = '0;
        byte_valid  = 1'b0;
        block_ready = 1'b1;
        flush       = 1'b0;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);

        check("rst_byte_ready", 128'(byte_ready), 128'(1'b0));
        check("rst_block_valid", 128'(block_valid), 128'(1'b0));
        check("rst_byte_count", 128'(byte_count), 128'(0));
        check("rst_block_out", block_out, '0);
        check("rst_err_timeout", 128'(err_timeout), 128'(1'b0));
        rst_n = 1'b1;
        tick();
        check("post_rst_byte_ready", 128'(byte_ready), 128'(1'b1));

        // Back-to-back block with downstream ready
        send_bytes(8'h00, 15);
        check("b2b_15_valid", 128'(block_valid), 128'(1'b0));
        check("b2b_15_count", 128'(byte_count), 128'(15));
        send_bytes(8'h0F, 1);
        check("b2b_valid", 128'(block_valid), 128'(1'b1));
        check("b2b_block", block_out, BLK_00);
        check("b2b_count16", 128'(byte_count), 128'(16));
        check("b2b_ready_low", 128'(byte_ready), 128'(1'b0));
        tick();
        check("b2b_valid_drop", 128'(block_valid), 128'(1'b0));
        check("b2b_ready_back", 128'(byte_ready), 128'(1'b1));
        check("b2b_count0", 128'(byte_count), 128'(0));

        // Backpressure with junk bytes and a flush attempt in HOLD
        block_ready = 1'b0;
        send_bytes(8'h10, 16);
        byte_valid = 1'b1;
        byte_in    = 8'hFF;
        for (int i = 0; i < 20; i++) begin
            flush = (i == 5);
            tick();
            check("bp_block", block_out, BLK_10);
            check("bp_ready", 128'(byte_ready), 128'(1'b0));
            check("bp_valid", 128'(block_valid), 128'(1'b1));
        end
        flush = 1'b0;
        check("bp_count16", 128'(byte_count), 128'(16));
        block_ready = 1'b1;
        tick();
        byte_valid = 1'b0;
        check("bp_handoff_valid", 128'(block_valid), 128'(1'b0));
        check("bp_handoff_count", 128'(byte_count), 128'(0));

        // Flush a partial block, then a clean block
        send_bytes(8'h50, 5);
        check("fl_count5", 128'(byte_count), 128'(5));
        flush      = 1'b1;
        byte_valid = 1'b1;
        byte_in    = 8'h99;
        tick();
        flush      = 1'b0;
        byte_valid = 1'b0;
        check("fl_count0", 128'(byte_count), 128'(0));
        send_bytes(8'hA0, 16);
        check("fl_valid", 128'(block_valid), 128'(1'b1));
        check("fl_block", block_out, BLK_A0);
        tick();

        // Asynchronous reset mid-block
        send_bytes(8'h60, 9);
        check("mr_count9", 128'(byte_count), 128'(9));
        #2 rst_n = 1'b0;
        #1;
        check("mr_count0", 128'(byte_count), 128'(0));
        check("mr_valid0", 128'(block_valid), 128'(1'b0));
        check("mr_block0", block_out, '0);
        check("mr_ready0", 128'(byte_ready), 128'(1'b0));
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("mr_ready1", 128'(byte_ready), 128'(1'b1));
        send_bytes(8'hC0, 16);
        check("mr_valid", 128'(block_valid), 128'(1'b1));
        check("mr_block", block_out, BLK_C0);
        tick();

        // Randomly gapped byte_valid gives the same block
        for (int i = 0; i < 16; i++) begin
            byte_valid = 1'b0;
            repeat ($urandom_range(0, 1)) tick();
            byte_valid = 1'b1;
            byte_in    = 8'(i);
            tick();
        end
        byte_valid = 1'b0;
        check("gap_valid", 128'(block_valid), 128'(1'b1));
        check("gap_block", block_out, BLK_00);
        tick();

        // Idle partial block
        send_bytes(8'h31, 3);
`ifdef AES_ASM_TIMEOUT_EN
        for (int n = 1; n <= 10; n++) begin
            tick();
            check($sformatf("to_err_%0d", n), 128'(err_timeout), 128'(n == 8));
            if (n == 7) check("to_count_before", 128'(byte_count), 128'(3));
            if (n == 8) check("to_count_after", 128'(byte_count), 128'(0));
        end
`else
        for (int n = 1; n <= 20; n++) begin
            tick();
            check($sformatf("idle_err_%0d", n), 128'(err_timeout), 128'(1'b0));
        end
        check("idle_count_kept", 128'(byte_count), 128'(3));
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("idle_flushed", 128'(byte_count), 128'(0));
`endif
        send_bytes(8'hD0, 16);
        check("post_idle_valid", 128'(block_valid), 128'(1'b1));
        check("post_idle_block", block_out, BLK_D0);
        tick();
        check("post_idle_drop", 128'(block_valid), 128'(1'b0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_aes_block_assembler
